// File: rtl/m68k_bus_arbiter.sv
// Purpose : 68K bus arbiter between the Pistorm transfer engine and Amiga DMA masters (BR/BG/BGACK).
// Latency : BR_n falling before edge N with the bus idle gives BG_n low after edge N+2 (two-flop sync + state).
// Backpr. : a Pi cycle in progress (bus_idle=0) is never interrupted; op_start_en holds the Pi engine in S0.
//
// Ports   : c7m (clock), op_reqrst (async active-high reset), op_req (Pi transfer pending),
//           bus_idle (transfer FSM in S0), M68K_BR_n / M68K_BGACK_n / M68K_AS_n_in (bus, async),
//           M68K_BG_n (grant), bus_own (Pi drives bus), op_start_en (Pi may start), dma_busy.
// Option  : define ARB_GRANT_TIMEOUT_EN to abandon a grant that is never acknowledged after 15 clocks.

module m68k_bus_arbiter (
    input  logic c7m,
    input  logic op_reqrst,
    input  logic op_req,
    input  logic bus_idle,
    input  logic M68K_BR_n,
    input  logic M68K_BGACK_n,
    input  logic M68K_AS_n_in,
    output logic M68K_BG_n,
    output logic bus_own,
    output logic op_start_en,
    output logic dma_busy
);

    typedef enum logic [3:0] {
        ST_OWN     = 4'b0001,
        ST_GRANT   = 4'b0010,
        ST_DMA     = 4'b0100,
        ST_RELEASE = 4'b1000
    } arb_state_t;

    arb_state_t state, state_nxt;
    logic       pi_turn, pi_turn_nxt;

    // Synchronizers keep the raw active-low levels; reset value 1 means "negated".
    logic [1:0] br_sync, bgack_sync, as_sync;
    logic       br_s, bgack_s, as_s;
    logic       br_s_nxt;

    always_ff @(posedge c7m or posedge op_reqrst) begin
        if (op_reqrst) begin
            br_sync    <= 2'b11;
            bgack_sync <= 2'b11;
            as_sync    <= 2'b11;
        end else begin
            br_sync    <= {br_sync[0],    M68K_BR_n};
            bgack_sync <= {bgack_sync[0], M68K_BGACK_n};
            as_sync    <= {as_sync[0],    M68K_AS_n_in};
        end
    end

    assign br_s     = ~br_sync[1];
    assign bgack_s  = ~bgack_sync[1];
    assign as_s     = ~as_sync[1];
    // Value br_s takes after the coming edge; lets op_start_en be registered
    // while still tracking the live br_s/pi_turn combination.
    assign br_s_nxt = ~br_sync[0];

`ifdef ARB_GRANT_TIMEOUT_EN
    // Counts GRANT clocks, saturating at 15 so a late BGACK drop still times out.
    logic [3:0] grant_cnt, grant_cnt_nxt;
`endif

    always_comb begin
        state_nxt   = state;
        pi_turn_nxt = pi_turn;
`ifdef ARB_GRANT_TIMEOUT_EN
        grant_cnt_nxt = grant_cnt;
`endif
        unique case (state)
            ST_OWN: begin
                // First clock of a Pi cycle consumes the Pi's reserved turn.
                if (!bus_idle)
                    pi_turn_nxt = 1'b0;
                if (br_s && bus_idle && !pi_turn) begin
                    state_nxt = ST_GRANT;
`ifdef ARB_GRANT_TIMEOUT_EN
                    grant_cnt_nxt = 4'd0;
`endif
                end
            end
            ST_GRANT: begin
`ifdef ARB_GRANT_TIMEOUT_EN
                grant_cnt_nxt = (grant_cnt == 4'd15) ? 4'd15 : grant_cnt + 4'd1;
`endif
                // Master may take the bus only once the last strobe is off.
                if (bgack_s && !as_s)
                    state_nxt = ST_DMA;
                else if (!br_s && !bgack_s)
                    state_nxt = ST_OWN;
`ifdef ARB_GRANT_TIMEOUT_EN
                else if (grant_cnt_nxt == 4'd15 && !bgack_s) begin
                    state_nxt   = ST_OWN;
                    pi_turn_nxt = op_req;
                end
`endif
            end
            ST_DMA: begin
                if (!bgack_s)
                    state_nxt = ST_RELEASE;
            end
            ST_RELEASE: begin
                // Reserve one Pi transfer before the next DMA tenure.
                state_nxt   = ST_OWN;
                pi_turn_nxt = op_req;
            end
            default: begin
                state_nxt   = ST_OWN;
                pi_turn_nxt = 1'b0;
            end
        endcase
    end

    // State and all outputs registered together so the pins never glitch.
    always_ff @(posedge c7m or posedge op_reqrst) begin
        if (op_reqrst) begin
            state       <= ST_OWN;
            pi_turn     <= 1'b0;
            M68K_BG_n   <= 1'b1;
            bus_own     <= 1'b1;
            dma_busy    <= 1'b0;
            op_start_en <= 1'b1;
        end else begin
            state       <= state_nxt;
            pi_turn     <= pi_turn_nxt;
            M68K_BG_n   <= (state_nxt != ST_GRANT);
            bus_own     <= (state_nxt == ST_OWN);
            dma_busy    <= (state_nxt == ST_DMA) || (state_nxt == ST_RELEASE);
            op_start_en <= (state_nxt == ST_OWN) && !(br_s_nxt && !pi_turn_nxt);
        end
    end

`ifdef ARB_GRANT_TIMEOUT_EN
    always_ff @(posedge c7m or posedge op_reqrst) begin
        if (op_reqrst)
            grant_cnt <= 4'd0;
        else
            grant_cnt <= grant_cnt_nxt;
    end
`endif

endmodule

// File: tb/tb_m68k_bus_arbiter.sv
// Purpose : self-checking bench for m68k_bus_arbiter, directed scenarios plus randomized traffic.
// Latency : outputs compared every clock on the falling edge against a behavioural model.
// Backpr. : the bench plays both the Pi transfer engine (bus_idle/op_req) and the DMA master.

module tb_m68k_bus_arbiter;

    logic c7m = 1'b0;
    always #5 c7m = ~c7m;

    logic op_reqrst, op_req, bus_idle;
    logic M68K_BR_n, M68K_BGACK_n, M68K_AS_n_in;
    logic M68K_BG_n, bus_own, op_start_en, dma_busy;

    m68k_bus_arbiter dut (
        .c7m          (c7m),
        .op_reqrst    (op_reqrst),
        .op_req       (op_req),
        .bus_idle     (bus_idle),
        .M68K_BR_n    (M68K_BR_n),
        .M68K_BGACK_n (M68K_BGACK_n),
        .M68K_AS_n_in (M68K_AS_n_in),
        .M68K_BG_n    (M68K_BG_n),
        .bus_own      (bus_own),
        .op_start_en  (op_start_en),
        .dma_busy     (dma_busy)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: who holds the bus, the Pi's reserved turn, and how
    // long the current grant has been outstanding. Bus inputs are seen through
    // a two-sample history (front = value the arbiter acts on).
    localparam int M_OWN = 0, M_GRANT = 1, M_DMA = 2, M_REL = 3;
    int m_mode;
    bit m_pi;
    int m_gclk;
    bit m_br_q[$], m_bgk_q[$], m_as_q[$];

    task automatic model_reset();
        m_mode  = M_OWN;
        m_pi    = 1'b0;
        m_gclk  = 0;
        m_br_q  = '{1'b0, 1'b0};
        m_bgk_q = '{1'b0, 1'b0};
        m_as_q  = '{1'b0, 1'b0};
    endtask

    task automatic model_tick();
        bit br, bgk, as_a;
        br   = m_br_q[0];
        bgk  = m_bgk_q[0];
        as_a = m_as_q[0];
        case (m_mode)
            M_OWN: begin
                if (br && bus_idle && !m_pi) begin
                    m_mode = M_GRANT;
                    m_gclk = 0;
                end
                if (!bus_idle) m_pi = 1'b0;
            end
            M_GRANT: begin
                m_gclk++;
                if (bgk && !as_a) m_mode = M_DMA;
                else if (!br && !bgk) m_mode = M_OWN;
`ifdef ARB_GRANT_TIMEOUT_EN
                else if (m_gclk >= 15 && !bgk) begin
                    m_mode = M_OWN;
                    m_pi   = op_req;
                end
`endif
            end
            M_DMA: if (!bgk) m_mode = M_REL;
            default: begin
                m_mode = M_OWN;
                m_pi   = op_req;
            end
        endcase
        void'(m_br_q.pop_front());  m_br_q.push_back(!M68K_BR_n);
        void'(m_bgk_q.pop_front()); m_bgk_q.push_back(!M68K_BGACK_n);
        void'(m_as_q.pop_front());  m_as_q.push_back(!M68K_AS_n_in);
    endtask

    task automatic compare_all(input string tag);
        chk_eq({tag, ".bg_n"},     M68K_BG_n,   (m_mode != M_GRANT));
        chk_eq({tag, ".bus_own"},  bus_own,     (m_mode == M_OWN));
        chk_eq({tag, ".dma_busy"}, dma_busy,    (m_mode == M_DMA) || (m_mode == M_REL));
        chk_eq({tag, ".start_en"}, op_start_en, (m_mode == M_OWN) && !(m_br_q[0] && !m_pi));
    endtask

    // Drive one clock of inputs (called just after a falling edge), advance
    // the model on the rising edge, compare on the next falling edge.
    task automatic step(input logic br_n, input logic bgk_n, input logic as_n,
                        input logic idle, input logic req, input string tag);
        M68K_BR_n    = br_n;
        M68K_BGACK_n = bgk_n;
        M68K_AS_n_in = as_n;
        bus_idle     = idle;
        op_req       = req;
        @(posedge c7m);
        model_tick();
        @(negedge c7m);
        compare_all(tag);
    endtask

    task automatic pulse_reset(input string tag);
        op_reqrst = 1'b1;
        model_reset();
        #1;
        chk_eq({tag, ".bg_n"},     M68K_BG_n,   1'b1);
        chk_eq({tag, ".bus_own"},  bus_own,     1'b1);
        chk_eq({tag, ".dma_busy"}, dma_busy,    1'b0);
        chk_eq({tag, ".start_en"}, op_start_en, 1'b1);
        #1;
        op_reqrst = 1'b0;
    endtask

    logic r_br, r_bgk, r_as, r_idle, r_req;
    int   low_cnt;
    bit   fell;

    initial begin
        op_reqrst    = 1'b0;
        op_req       = 1'b0;
        bus_idle     = 1'b1;
        M68K_BR_n    = 1'b1;
        M68K_BGACK_n = 1'b1;
        M68K_AS_n_in = 1'b1;
        #1;
        // Reset values
        pulse_reset("reset");
        @(negedge c7m);

        // Idle bus: grant two edges after BR, then DMA on BGACK with AS off
        step(0, 1, 1, 1, 0, "grant0");
        step(0, 1, 1, 1, 0, "grant1");
        chk_eq("grant_not_yet", M68K_BG_n, 1'b1);
        step(0, 1, 1, 1, 0, "grant2");
        chk_eq("grant_latency", M68K_BG_n, 1'b0);
        chk_eq("grant_bus_own", bus_own, 1'b0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 0, "to_dma");
        chk_eq("dma_bg_n", M68K_BG_n, 1'b1);
        chk_eq("dma_busy", dma_busy, 1'b1);

        // Reset in DMA returns the bus immediately; master released afterwards
        pulse_reset("rst_in_dma");
        for (int i = 0; i < 6; i++) step(0, 0, 1, 1, 0, "after_rst");
        for (int i = 0; i < 6; i++) step(1, 1, 1, 1, 0, "drain0");
        chk_eq("drain0_own", bus_own, 1'b1);

        // BR during a Pi cycle: no grant until the cycle ends
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 1, 0, 1, "pi_busy");
            chk_eq("pi_busy_bg", M68K_BG_n, 1'b1);
            if (i >= 1) chk_eq("pi_busy_en", op_start_en, 1'b0);
        end
        fell = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step(0, 1, 1, 1, 0, "pi_done");
            if (M68K_BG_n == 1'b0) fell = 1'b1;
        end
        chk_eq("grant_after_idle", fell, 1'b1);

        // BR held, op_req pending, BGACK released: one Pi transfer between tenures
        for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 1, "dma2");
        chk_eq("dma2_busy", dma_busy, 1'b1);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 1, "rel");
        chk_eq("release_busy", dma_busy, 1'b1);
        chk_eq("release_own", bus_own, 1'b0);
        step(0, 1, 1, 1, 1, "back_own");
        chk_eq("pi_turn_own", bus_own, 1'b1);
        chk_eq("pi_turn_en", op_start_en, 1'b1);
        step(0, 1, 1, 1, 1, "pi_turn_hold");
        chk_eq("pi_turn_hold_bg", M68K_BG_n, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 1, 0, 1, "pi_xfer");
            chk_eq("pi_xfer_bg", M68K_BG_n, 1'b1);
        end
        step(0, 1, 1, 1, 0, "regrant");
        chk_eq("regrant_bg", M68K_BG_n, 1'b0);
        for (int i = 0; i < 5; i++) step(1, 1, 1, 1, 0, "drain1");

        // BR withdrawn without BGACK: grant retracted
        for (int i = 0; i < 4; i++) step(0, 1, 1, 1, 0, "br4");
        chk_eq("br4_granted", M68K_BG_n, 1'b0);
        for (int i = 0; i < 4; i++) step(1, 1, 1, 1, 0, "br_off");
        chk_eq("withdraw_bg", M68K_BG_n, 1'b1);
        chk_eq("withdraw_own", bus_own, 1'b1);
        chk_eq("withdraw_en", op_start_en, 1'b1);

        // Grant never acknowledged
        for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 0, "nack_enter");
        low_cnt = (M68K_BG_n == 1'b0) ? 1 : 0;
        for (int i = 0; i < 100; i++) begin
            step(0, 1, 1, 1, 0, "nack");
            if (M68K_BG_n == 1'b0 && low_cnt == i + 1) low_cnt++;
        end
`ifdef ARB_GRANT_TIMEOUT_EN
        chk_eq("timeout_len", low_cnt, 15);
`else
        chk_eq("no_timeout_len", low_cnt, 101);
`endif
        for (int i = 0; i < 5; i++) step(1, 1, 1, 1, 0, "drain2");

        // Randomized traffic with occasional asynchronous resets
        r_br = 1; r_bgk = 1; r_as = 1; r_idle = 1; r_req = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(7) == 0) r_br   = ~r_br;
            if ($urandom_range(5) == 0) r_bgk  = ~r_bgk;
            if ($urandom_range(3) == 0) r_as   = ~r_as;
            if ($urandom_range(4) == 0) r_idle = ~r_idle;
            if ($urandom_range(9) == 0) r_req  = ~r_req;
            if ($urandom_range(499) == 0) pulse_reset("rnd_rst");
            step(r_br, r_bgk, r_as, r_idle, r_req, "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
